pp_accumulator: RTL



---
 rtl/pp_acc_pkg.sv | 26 ++
 rtl/pp_term_select.sv | 41 ++++
 rtl/pp_accumulator.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pp_acc_pkg.sv
// Shared constants, FSM state encoding and step-count helper for pp_accumulator.
// The optional PP_ACC_TWO_PER_CYCLE_EN macro selects two terms per accumulate step.
package pp_acc_pkg;

    localparam int unsigned PP_DATA_WIDTH       = 32;
    localparam int unsigned PP_DATA_WIDTH_TERMS = PP_DATA_WIDTH * 2;
    localparam int unsigned PP_NUM_TERMS        = 12;

`ifdef PP_ACC_TWO_PER_CYCLE_EN
    localparam int unsigned PP_TERMS_PER_STEP = 2;
`else
    localparam int unsigned PP_TERMS_PER_STEP = 1;
`endif

    typedef enum logic [1:0] {
        PP_IDLE  = 2'd0,
        PP_ACCUM = 2'd1,
        PP_DONE  = 2'd2
    } pp_acc_state_e;

    // Number of accumulate cycles needed to consume num_terms terms.
    function automatic int unsigned pp_acc_steps(input int unsigned num_terms);
        return (num_terms + PP_TERMS_PER_STEP - 1) / PP_TERMS_PER_STEP;
    endfunction

endpackage

// File: rtl/pp_term_select.sv
// Combinational term picker: returns term[idx] and, when PP_ACC_TWO_PER_CYCLE_EN
// is defined, also term[idx+1] (zero once idx+1 runs past the last term).
module pp_term_select
    import pp_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_TERMS = PP_DATA_WIDTH_TERMS,
    parameter int unsigned NUM_TERMS        = PP_NUM_TERMS,
    parameter int unsigned CAPACITY_RESULT  = DATA_WIDTH_TERMS * NUM_TERMS,
    parameter int unsigned IDX_W            = $clog2(NUM_TERMS)
) (
    input  logic [CAPACITY_RESULT-1:0]  terms,
    input  logic [IDX_W-1:0]            idx,
`ifdef PP_ACC_TWO_PER_CYCLE_EN
    output logic [DATA_WIDTH_TERMS-1:0] term_b_c,
`endif
    output logic [DATA_WIDTH_TERMS-1:0] term_a_c
);

    // Primary term: term[idx].
    always_comb begin
        term_a_c = '0;
        for (int unsigned k = 0; k < NUM_TERMS; k++) begin
            if (idx == IDX_W'(k)) begin
                term_a_c = terms[k*DATA_WIDTH_TERMS +: DATA_WIDTH_TERMS];
            end
        end
    end

`ifdef PP_ACC_TWO_PER_CYCLE_EN
    // Companion term: term[idx+1], zero when idx is the last term.
    always_comb begin
        term_b_c = '0;
        for (int unsigned k = 0; k < NUM_TERMS; k++) begin
            if (({1'b0, idx} + (IDX_W+1)'(1)) == (IDX_W+1)'(k)) begin
                term_b_c = terms[k*DATA_WIDTH_TERMS +: DATA_WIDTH_TERMS];
            end
        end
    end
`endif

endmodule

// File: rtl/pp_accumulator.sv
// Iterative partial-product accumulator: latches a bundle of NUM_TERMS terms and
// sums them modulo 2^DATA_WIDTH_TERMS over several cycles, valid/ready on both sides.
// Optional macro PP_ACC_TWO_PER_CYCLE_EN: consume two terms per accumulate cycle.
module pp_accumulator
    import pp_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = PP_DATA_WIDTH,
    parameter int unsigned DATA_WIDTH_TERMS = DATA_WIDTH * 2,
    parameter int unsigned NUM_TERMS        = PP_NUM_TERMS,
    parameter int unsigned CAPACITY_RESULT  = DATA_WIDTH_TERMS * NUM_TERMS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CAPACITY_RESULT-1:0]  terms,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH_TERMS-1:0] product
);

    localparam int unsigned IDX_W    = $clog2(NUM_TERMS);
    localparam int unsigned LAST_IDX = (pp_acc_steps(NUM_TERMS) - 1) * PP_TERMS_PER_STEP;

    localparam logic [1:0] ST_IDLE  = PP_IDLE;
    localparam logic [1:0] ST_ACCUM = PP_ACCUM;
    localparam logic [1:0] ST_DONE  = PP_DONE;

    logic [1:0]                  state_q, state_d;
    logic [CAPACITY_RESULT-1:0]  term_q, term_d;
    logic [DATA_WIDTH_TERMS-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [DATA_WIDTH_TERMS-1:0] product_d;
    logic                        out_valid_d;
    logic                        in_ready_d;
    logic [DATA_WIDTH_TERMS-1:0] term_a_c;
    logic [DATA_WIDTH_TERMS-1:0] step_sum_c;

`ifdef PP_ACC_TWO_PER_CYCLE_EN
    logic [DATA_WIDTH_TERMS-1:0] term_b_c;

    pp_term_select #(
        .DATA_WIDTH_TERMS (DATA_WIDTH_TERMS),
        .NUM_TERMS        (NUM_TERMS),
        .CAPACITY_RESULT  (CAPACITY_RESULT),
        .IDX_W            (IDX_W)
    ) u_term_select (
        .terms    (term_q),
        .idx      (idx_q),
        .term_b_c (term_b_c),
        .term_a_c (term_a_c)
    );

    // Pair of terms added in one step; carries past the MSB are dropped.
    assign step_sum_c = term_a_c + term_b_c;
`else
    pp_term_select #(
        .DATA_WIDTH_TERMS (DATA_WIDTH_TERMS),
        .NUM_TERMS        (NUM_TERMS),
        .CAPACITY_RESULT  (CAPACITY_RESULT),
        .IDX_W            (IDX_W)
    ) u_term_select (
        .terms    (term_q),
        .idx      (idx_q),
        .term_a_c (term_a_c)
    );

    assign step_sum_c = term_a_c;
`endif

    // Next-state and next-register logic; outputs derive from the next state.
    always_comb begin
        state_d   = state_q;
        term_d    = term_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        product_d = product;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    term_d  = terms;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + step_sum_c;
                if (idx_q == IDX_W'(LAST_IDX)) begin
                    idx_d     = '0;
                    product_d = acc_d;
                    state_d   = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(PP_TERMS_PER_STEP);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    // State and datapath registers; async reset returns to an empty IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            term_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            term_q    <= term_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            product   <= product_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule
